register_file_mp: RTL and testbench

- Parametrised multi-port integer register file with an integrated write-back scoreboard.
- Successor to the single-write, two-read register file.
- Supports N read ports, M write ports (ALU write-back plus long-latency/LSU write-back), same-cycle write-to-read bypass, and per-register busy tracking for the issue stage.
- Sits between decode/issue and the write-back stage of the core pipeline.

---
 rtl/riscv_core_pkg.sv | 6 +
 rtl/rf_scoreboard.sv | 41 ++++
 rtl/register_file_mp.sv | 57 +++++
 tb/tb_register_file_mp.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_pkg.sv
// riscv_core_pkg: shared register-file address type and constants
package riscv_core_pkg;
    localparam int REG_AW = $clog2(32);
    typedef logic [REG_AW-1:0] reg_addr_t;
    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits with reserve/clear/flush and write-masked read status
module rf_scoreboard import riscv_core_pkg::*; #(
    parameter int NUM_REGS = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int ZERO_REG = 1,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_RD*AW-1:0]   raddr_i,
    output logic [NUM_RD-1:0]      rbusy_o,
    input  logic [NUM_WR-1:0]      we_i,
    input  logic [NUM_WR*AW-1:0]   waddr_i,
    input  logic                   rsv_i,
    input  logic [AW-1:0]          rsv_addr_i,
    input  logic                   flush_i
);
    logic [NUM_REGS-1:0] busy, clr, set;
    always_comb begin
        clr = '0;
        for (int w = 0; w < NUM_WR; w++)
            if (we_i[w]) clr[waddr_i[w*AW +: AW]] = 1'b1;
    end
    // set is applied after clear so a same-cycle reserve wins over the retiring write
    assign set = (rsv_i && !(ZERO_REG != 0 && rsv_addr_i == AW'(REG_ZERO))) ? NUM_REGS'(1) << rsv_addr_i : '0;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) busy <= '0;
        else busy <= flush_i ? '0 : (busy & ~clr) | set;
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rb
        logic [AW-1:0] ra;
        logic hit;
        assign ra = raddr_i[p*AW +: AW];
        always_comb begin
            hit = 1'b0;
            for (int w = 0; w < NUM_WR; w++)
                hit = hit | (we_i[w] && waddr_i[w*AW +: AW] == ra);
        end
        assign rbusy_o[p] = busy[ra] & ~hit;
    end
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with write bypass and issue scoreboard
module register_file_mp import riscv_core_pkg::*; #(
    parameter int XLEN = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int ZERO_REG = 1,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_RD*AW-1:0]   raddr_i,
    output logic [NUM_RD*XLEN-1:0] rdata_o,
    output logic [NUM_RD-1:0]      rbusy_o,
    input  logic [NUM_WR-1:0]      we_i,
    input  logic [NUM_WR*AW-1:0]   waddr_i,
    input  logic [NUM_WR*XLEN-1:0] wdata_i,
    input  logic                   rsv_i,
    input  logic [AW-1:0]          rsv_addr_i,
    input  logic                   flush_i
);
    logic [XLEN-1:0] regs [NUM_REGS];
    // later ports overwrite earlier ones, giving the highest index priority
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) regs <= '{default: '0};
        else
            for (int w = 0; w < NUM_WR; w++)
                if (we_i[w] && !(ZERO_REG != 0 && waddr_i[w*AW +: AW] == AW'(REG_ZERO)))
                    regs[waddr_i[w*AW +: AW]] <= wdata_i[w*XLEN +: XLEN];
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic [XLEN-1:0] d;
        assign ra = raddr_i[p*AW +: AW];
        always_comb begin
            d = regs[ra];
            for (int w = 0; w < NUM_WR; w++)
                d = (we_i[w] && waddr_i[w*AW +: AW] == ra) ? wdata_i[w*XLEN +: XLEN] : d;
        end
        assign rdata_o[p*XLEN +: XLEN] = (ZERO_REG != 0 && ra == AW'(REG_ZERO)) ? '0 : d;
    end
    rf_scoreboard #(
        .NUM_REGS(NUM_REGS),
        .NUM_RD(NUM_RD),
        .NUM_WR(NUM_WR),
        .ZERO_REG(ZERO_REG)
    ) u_sb (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .raddr_i(raddr_i),
        .rbusy_o(rbusy_o),
        .we_i(we_i),
        .waddr_i(waddr_i),
        .rsv_i(rsv_i),
        .rsv_addr_i(rsv_addr_i),
        .flush_i(flush_i)
    );
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed and randomized checks of register_file_mp against a behavioural model
module tb_register_file_mp;
    localparam int XLEN = 32, NR = 32, AW = 5, NRD = 2, NWR = 2;
    logic clk = 1'b0, rst = 1'b1;
    logic [NRD*AW-1:0] raddr = '0;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0] rbusy;
    logic [NWR-1:0] we = '0;
    logic [NWR*AW-1:0] waddr = '0;
    logic [NWR*XLEN-1:0] wdata = '0;
    logic rsv = 1'b0, flush = 1'b0;
    logic [AW-1:0] rsv_addr = '0;
    int errors = 0, checks = 0;
    logic [XLEN-1:0] m_regs [NR];
    bit m_busy [NR];

    register_file_mp dut (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .rsv_i(rsv), .rsv_addr_i(rsv_addr), .flush_i(flush)
    );

    always #5 clk = ~clk;

    function automatic bit written(logic [AW-1:0] a);
        for (int w = 0; w < NWR; w++)
            if (we[w] && waddr[w*AW +: AW] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] exp_rdata(logic [AW-1:0] a);
        logic [XLEN-1:0] d;
        if (a == 0) return '0;
        d = m_regs[a];
        for (int w = 0; w < NWR; w++)
            if (we[w] && waddr[w*AW +: AW] == a) d = wdata[w*XLEN +: XLEN];
        return d;
    endfunction

    function automatic bit exp_rbusy(logic [AW-1:0] a);
        return a != 0 && m_busy[a] && !written(a);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic tick();
        for (int w = 0; w < NWR; w++)
            if (we[w] && waddr[w*AW +: AW] != 0) m_regs[waddr[w*AW +: AW]] = wdata[w*XLEN +: XLEN];
        if (flush) for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        else begin
            for (int w = 0; w < NWR; w++)
                if (we[w]) m_busy[waddr[w*AW +: AW]] = 1'b0;
            if (rsv && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = '0;
        rsv = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        model_clear();
        idle();
        for (int a = 1; a < NR; a++) begin
            raddr = {AW'(a), AW'(a)};
            #1;
            checks++;
            if ({rdata, rbusy} !== '0) begin
                errors++;
                $display("FAIL reset_read a=%0d rdata=%h rbusy=%b want 0/0", a, rdata, rbusy);
            end
        end
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_priority();
        we = 2'b11;
        waddr = {5'd7, 5'd7};
        wdata = {32'h22222222, 32'h11111111};
        raddr = {5'd0, 5'd7};
        #2;
        checks++;
        if (rdata[XLEN-1:0] !== 32'h22222222) begin
            errors++;
            $display("FAIL prio_bypass rdata0=%h want 22222222", rdata[XLEN-1:0]);
        end
        tick();
        idle();
        raddr = {5'd7, 5'd7};
        #2;
        checks++;
        if (rdata !== {32'h22222222, 32'h22222222}) begin
            errors++;
            $display("FAIL prio_stored rdata=%h want 22222222 on both", rdata);
        end
    endtask

    task automatic test_zero_reg();
        we = 2'b11;
        waddr = '0;
        wdata = {32'hFFFFFFFF, 32'hFFFFFFFF};
        rsv = 1'b1;
        rsv_addr = '0;
        raddr = '0;
        #2;
        checks++;
        if ({rdata, rbusy} !== '0) begin
            errors++;
            $display("FAIL zero_same rdata=%h rbusy=%b want 0/0", rdata, rbusy);
        end
        tick();
        idle();
        #2;
        checks++;
        if ({rdata, rbusy} !== '0) begin
            errors++;
            $display("FAIL zero_next rdata=%h rbusy=%b want 0/0", rdata, rbusy);
        end
    endtask

    task automatic test_scoreboard();
        rsv = 1'b1;
        rsv_addr = 5'd10;
        tick();
        idle();
        raddr = {5'd10, 5'd10};
        #2;
        checks++;
        if (rbusy !== 2'b11) begin
            errors++;
            $display("FAIL rsv_busy rbusy=%b want 11", rbusy);
        end
        we = 2'b10;
        waddr = {5'd10, 5'd0};
        wdata = {32'h0000ABCD, 32'h0};
        #1;
        checks++;
        if (rbusy !== 2'b00 || rdata[XLEN-1:0] !== 32'h0000ABCD) begin
            errors++;
            $display("FAIL wr_release rbusy=%b rdata0=%h want 00/0000abcd", rbusy, rdata[XLEN-1:0]);
        end
        tick();
        idle();
        #2;
        checks++;
        if (rbusy !== 2'b00 || rdata !== {32'h0000ABCD, 32'h0000ABCD}) begin
            errors++;
            $display("FAIL wr_after rbusy=%b rdata=%h want 00/abcd", rbusy, rdata);
        end
    endtask

    task automatic test_rsv_and_write();
        rsv = 1'b1;
        rsv_addr = 5'd12;
        we = 2'b01;
        waddr = {5'd0, 5'd12};
        wdata = {32'h0, 32'h00000055};
        tick();
        idle();
        raddr = {5'd12, 5'd12};
        #2;
        checks++;
        if (rbusy !== 2'b11 || rdata[XLEN-1:0] !== 32'h00000055) begin
            errors++;
            $display("FAIL rsv_wins rbusy=%b rdata0=%h want 11/00000055", rbusy, rdata[XLEN-1:0]);
        end
    endtask

    task automatic test_flush();
        rsv = 1'b1;
        rsv_addr = 5'd3;
        tick();
        rsv_addr = 5'd4;
        tick();
        idle();
        raddr = {5'd4, 5'd3};
        #2;
        checks++;
        if (rbusy !== 2'b11) begin
            errors++;
            $display("FAIL pre_flush rbusy=%b want 11", rbusy);
        end
        flush = 1'b1;
        rsv = 1'b1;
        rsv_addr = 5'd5;
        we = 2'b01;
        waddr = {5'd0, 5'd9};
        wdata = {32'h0, 32'h00000099};
        tick();
        idle();
        #2;
        checks++;
        if (rbusy !== 2'b00) begin
            errors++;
            $display("FAIL flush_34 rbusy=%b want 00", rbusy);
        end
        raddr = {5'd9, 5'd5};
        #1;
        checks++;
        if (rbusy !== 2'b00 || rdata[2*XLEN-1:XLEN] !== 32'h00000099) begin
            errors++;
            $display("FAIL flush_59 rbusy=%b rdata1=%h want 00/00000099", rbusy, rdata[2*XLEN-1:XLEN]);
        end
    endtask

    task automatic test_mid_reset();
        we = 2'b01;
        waddr = {5'd0, 5'd5};
        wdata = {32'h0, 32'hDEADBEEF};
        tick();
        idle();
        rsv = 1'b1;
        rsv_addr = 5'd6;
        tick();
        idle();
        raddr = {5'd6, 5'd5};
        #1;
        checks++;
        if (rdata[XLEN-1:0] !== 32'hDEADBEEF || rbusy !== 2'b10) begin
            errors++;
            $display("FAIL pre_reset rdata0=%h rbusy=%b want deadbeef/10", rdata[XLEN-1:0], rbusy);
        end
        rst = 1'b1;
        model_clear();
        #1;
        checks++;
        if ({rdata, rbusy} !== '0) begin
            errors++;
            $display("FAIL async_reset rdata=%h rbusy=%b want 0/0", rdata, rbusy);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int w = 0; w < NWR; w++) begin
                we[w] = ($urandom_range(0, 99) < 40);
                waddr[w*AW +: AW] = AW'($urandom_range(0, 15));
                wdata[w*XLEN +: XLEN] = $urandom;
            end
            rsv = ($urandom_range(0, 99) < 35);
            rsv_addr = AW'($urandom_range(0, 15));
            flush = ($urandom_range(0, 99) < 5);
            for (int p = 0; p < NRD; p++)
                raddr[p*AW +: AW] = $urandom_range(0, 1) ? waddr[$urandom_range(0, NWR-1)*AW +: AW] : AW'($urandom_range(0, 15));
            #2;
            for (int p = 0; p < NRD; p++) begin
                checks++;
                if (rdata[p*XLEN +: XLEN] !== exp_rdata(raddr[p*AW +: AW]) || rbusy[p] !== exp_rbusy(raddr[p*AW +: AW])) begin
                    errors++;
                    $display("FAIL rand c=%0d port=%0d a=%0d rdata=%h rbusy=%b want %h/%b", c, p, raddr[p*AW +: AW],
                             rdata[p*XLEN +: XLEN], rbusy[p], exp_rdata(raddr[p*AW +: AW]), exp_rbusy(raddr[p*AW +: AW]));
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_priority();
        test_zero_reg();
        test_scoreboard();
        test_rsv_and_write();
        test_flush();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
